// File: rtl/vga_pkg.sv
// Shared timing constants, coordinate width and axis phase type for the VGA
// raster timing generator.
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} vga_phase_t;

    function automatic logic sync_level(input vga_phase_t ph, input logic pol);
        return (ph == PH_SYNC) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM, both
// stepping only when adv is high.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FP     = H_FP_DEF,
    parameter int unsigned SYNC   = H_SYNC_DEF,
    parameter int unsigned BP     = H_BP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv,
    output logic [COORD_W-1:0] count,
    output vga_phase_t         phase,
    output logic               wrap
);

    localparam int unsigned        TOTAL  = ACTIVE + FP + SYNC + BP;
    localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] B_FP   = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] B_SYNC = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] B_BP   = COORD_W'(ACTIVE + FP + SYNC);

    logic [COORD_W-1:0] count_q, count_d;
    vga_phase_t         phase_q;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + COORD_W'(1);
    end

    // Phase follows the position the counter is about to take, so both change together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= LAST;
            phase_q <= PH_BP;
        end else if (adv) begin
            count_q <= count_d;
            case (phase_q)
                PH_ACTIVE: if (count_d == B_FP)   phase_q <= PH_FP;
                PH_FP:     if (count_d == B_SYNC) phase_q <= PH_SYNC;
                PH_SYNC:   if (count_d == B_BP)   phase_q <= PH_BP;
                PH_BP:     if (count_d == '0)     phase_q <= PH_ACTIVE;
            endcase
        end
    end

    assign count = count_q;
    assign phase = phase_q;
    assign wrap  = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on a single clock: pixel-rate enable, syncs,
// display enable and pixel coordinates.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             pix_en_q;
    logic             tick;
    logic             h_wrap, v_wrap;
    vga_phase_t       h_phase, v_phase;

    // Reset parks the divider on its last count so the first released edge is a tick.
    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= DIV_LAST;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= tick ? '0 : div_q + DIV_W'(1);
            pix_en_q <= tick;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (tick),
        .count (x),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (tick & h_wrap),
        .count (y),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    assign pix_en      = pix_en_q;
    assign hsync       = sync_level(h_phase, SYNC_POL);
    assign vsync       = sync_level(v_phase, SYNC_POL);
    assign de          = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign line_start  = (x == '0);
    assign frame_start = (x == '0) && (y == '0);

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three generator configurations driven with random reset
// pulses, compared each clock against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic       hsync;
        logic       vsync;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       line_start;
        logic       frame_start;
    } out_t;

    typedef struct {
        int unsigned div;
        int unsigned ha, hf, hs, hb;
        int unsigned va, vf, vs, vb;
        bit          pol;
        int unsigned rst_odds;
    } cfg_t;

    localparam int NCYC = 40000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [3];
    logic       pe [3], hs [3], vs [3], de [3], ls [3], fs [3];
    logic [9:0] xo [3], yo [3];
    out_t       act [3];

    out_t q0 [$];
    out_t q1 [$];
    out_t q2 [$];

    int vectors     = 0;
    int miscompares = 0;

    initial begin
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    end

    vga_timing_gen u_dut0 (
        .clk (clk), .rst_n (rst_n[0]), .pix_en (pe[0]), .hsync (hs[0]), .vsync (vs[0]),
        .de (de[0]), .x (xo[0]), .y (yo[0]), .line_start (ls[0]), .frame_start (fs[0])
    );

    vga_timing_gen #(
        .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .SYNC_POL (1'b1)
    ) u_dut1 (
        .clk (clk), .rst_n (rst_n[1]), .pix_en (pe[1]), .hsync (hs[1]), .vsync (vs[1]),
        .de (de[1]), .x (xo[1]), .y (yo[1]), .line_start (ls[1]), .frame_start (fs[1])
    );

    vga_timing_gen #(
        .CLK_DIV (3), .H_ACTIVE (6), .H_FP (1), .H_SYNC (2), .H_BP (3),
        .V_ACTIVE (3), .V_FP (2), .V_SYNC (1), .V_BP (2), .SYNC_POL (1'b0)
    ) u_dut2 (
        .clk (clk), .rst_n (rst_n[2]), .pix_en (pe[2]), .hsync (hs[2]), .vsync (vs[2]),
        .de (de[2]), .x (xo[2]), .y (yo[2]), .line_start (ls[2]), .frame_start (fs[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_act
        assign act[g] = {pe[g], hs[g], vs[g], de[g], xo[g], yo[g], ls[g], fs[g]};
    end

    function automatic cfg_t get_cfg(input int k);
        cfg_t c;
        case (k)
            0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 4000};
            1:       c = '{1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 300};
            default: c = '{3, 6, 1, 2, 3, 3, 2, 1, 2, 1'b0, 300};
        endcase
        return c;
    endfunction

    // cyc = clock edges since the first released edge (that edge is cyc 0).
    function automatic out_t model(input cfg_t c, input bit in_rst, input int unsigned cyc);
        out_t        o;
        int unsigned ht, vt, p, px, py;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        if (in_rst) begin
            o.pix_en = 1'b0; o.de = 1'b0;
            o.hsync = ~c.pol; o.vsync = ~c.pol;
            o.x = 10'(ht - 1); o.y = 10'(vt - 1);
            o.line_start = 1'b0; o.frame_start = 1'b0;
        end else begin
            p  = cyc / c.div;
            px = p % ht;
            py = (p / ht) % vt;
            o.pix_en = ((cyc % c.div) == 0);
            o.hsync = (px >= c.ha + c.hf && px < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
            o.vsync = (py >= c.va + c.vf && py < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
            o.de = (px < c.ha) && (py < c.va);
            o.x = 10'(px);
            o.y = 10'(py);
            o.line_start = (px == 0);
            o.frame_start = (px == 0) && (py == 0);
        end
        return o;
    endfunction

    task automatic push(input int k, input out_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int k, output bit ok, output out_t e);
        ok = 1'b0;
        e  = '0;
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Monitor: one comparison per instance per clock, #1 after the edge.
    initial begin
        bit   ok;
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                pop(k, ok, e);
                if (ok) begin
                    vectors++;
                    if (act[k] !== e) begin
                        miscompares++;
                        $display("FAIL dut%0d vec%0d: got pe=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, want pe=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                                 k, vectors, act[k].pix_en, act[k].hsync, act[k].vsync, act[k].de,
                                 act[k].x, act[k].y, act[k].line_start, act[k].frame_start,
                                 e.pix_en, e.hsync, e.vsync, e.de, e.x, e.y, e.line_start, e.frame_start);
                    end
                end
            end
        end
    end

    // Stimulus: reset pulses at random points (plus one mid-line on dut0).
    initial begin
        int unsigned rem [3];
        int unsigned cyc [3];
        cfg_t        c;
        bit          r;
        for (int k = 0; k < 3; k++) begin
            rem[k] = 3;
            cyc[k] = 0;
        end
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            if (n == 5300) rem[0] = 2;
            for (int k = 0; k < 3; k++) begin
                c = get_cfg(k);
                if (rem[k] > 0) begin
                    r = 1'b0;
                    rem[k]--;
                end else if ($urandom_range(c.rst_odds - 1, 0) == 0) begin
                    r = 1'b0;
                    rem[k] = $urandom_range(2, 0);
                end else begin
                    r = 1'b1;
                end
                rst_n[k] = r;
                if (r) begin
                    push(k, model(c, 1'b0, cyc[k]));
                    cyc[k]++;
                end else begin
                    push(k, model(c, 1'b1, 0));
                    cyc[k] = 0;
                end
            end
        end
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", q0.size() + q1.size() + q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
